// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder slice per clock, LSB first, start/busy/done handshake.
// Define SERIAL_ADD_SUB_EN to add the sub port (A-B via inverted B and carry-in of 1).
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  // a_q doubles as the result register: sum bits enter at the MSB as operand bits leave.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             s_bit, c_next;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  always_comb begin
    s_bit  = a_q[0] ^ b_q[0] ^ carry_q;
    c_next = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & carry_q);
  end

  always_comb begin
`ifdef SERIAL_ADD_SUB_EN
    b_load = sub ? ~op_b : op_b;
    c_load = sub ? 1'b1 : cin;
`else
    b_load = op_b;
    c_load = cin;
`endif
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = op_a;
          b_d     = b_load;
          carry_d = c_load;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = {s_bit, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = c_next;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = {s_bit, a_q[WIDTH-1:1]};
          cout_d  = c_next;
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: WIDTH=8 directed/random plus exhaustive WIDTH=2/4.
// Subtraction checks are compiled in when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] op_a, op_b;
  logic       cin;
  logic       start8, start2, start4;
  logic       busy8, done8, cout8;
  logic       busy2, done2, cout2;
  logic       busy4, done4, cout4;
  logic [7:0] sum8;
  logic [1:0] sum2;
  logic [3:0] sum4;
`ifdef SERIAL_ADD_SUB_EN
  logic       sub_in;
`endif

  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] prev_sum [3];

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub_in),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .op_a(op_a[1:0]), .op_b(op_b[1:0]), .cin(cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub(1'b0),
`endif
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op_a(op_a[3:0]), .op_b(op_b[3:0]), .cin(cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub(1'b0),
`endif
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int idx(input int w);
    return (w == 8) ? 0 : ((w == 2) ? 1 : 2);
  endfunction

  task automatic outs(input int w, output logic b, output logic d, output logic [7:0] s,
                      output logic c);
    case (w)
      2: begin b = busy2; d = done2; s = {6'd0, sum2}; c = cout2; end
      4: begin b = busy4; d = done4; s = {4'd0, sum4}; c = cout4; end
      default: begin b = busy8; d = done8; s = sum8; c = cout8; end
    endcase
  endtask

  task automatic set_start(input int w, input logic v);
    case (w)
      2: start2 = v;
      4: start4 = v;
      default: start8 = v;
    endcase
  endtask

  // One full operation on the width-w instance; starts and ends #1 after a rising edge in IDLE.
  task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic sb);
    logic [7:0]  mask, es, s;
    int unsigned bb, tot;
    logic        ec, bo, d, co, seen;
    int          edges;
    mask = 8'((1 << w) - 1);
    bb   = sb ? int'(~b & mask) : int'(b & mask);
    tot  = int'(a & mask) + bb + (sb ? 1 : int'(c));
    es   = 8'(tot & mask);
    ec   = 1'((tot >> w) & 1);
    op_a = a; op_b = b; cin = c;
`ifdef SERIAL_ADD_SUB_EN
    sub_in = sb;
`endif
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    op_a = 8'($urandom); op_b = 8'($urandom); cin = 1'($urandom);
    edges = 0; seen = 1'b0;
    while (!seen && edges < 3 * w + 4) begin
      outs(w, bo, d, s, co);
      if (d) seen = 1'b1;
      else begin
        check($sformatf("busy_run_w%0d", w), bo, 1);
        check($sformatf("sum_hold_w%0d", w), s, prev_sum[idx(w)]);
        @(posedge clk); #1;
        edges++;
      end
    end
    check($sformatf("done_seen_w%0d", w), seen, 1);
    check($sformatf("latency_w%0d", w), edges, w);
    check($sformatf("sum_w%0d a=%0h b=%0h c=%0d s=%0d", w, a, b, c, sb), s, es);
    check($sformatf("cout_w%0d a=%0h b=%0h c=%0d s=%0d", w, a, b, c, sb), co, ec);
    check($sformatf("busy_done_w%0d", w), bo, 1);
    @(posedge clk); #1;
    outs(w, bo, d, s, co);
    check($sformatf("busy_idle_w%0d", w), bo, 0);
    check($sformatf("done_pulse_w%0d", w), d, 0);
    check($sformatf("sum_after_w%0d", w), s, es);
    prev_sum[idx(w)] = es;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int dones, edges;
    rst_n = 1'b0; start8 = 0; start2 = 0; start4 = 0;
    op_a = 0; op_b = 0; cin = 0;
`ifdef SERIAL_ADD_SUB_EN
    sub_in = 0;
`endif
    for (int i = 0; i < 3; i++) prev_sum[i] = 8'h00;
    #12;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_sum", sum8, 0);
    check("rst_cout", cout8, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8, 8'h5A, 8'h3C, 1'b0, 1'b0);
    run_op(8, 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8, 8'hFF, 8'hFF, 1'b1, 1'b0);

    // Held start and changing operands during RUN/DONE must not be accepted.
    op_a = 8'h11; op_b = 8'h22; cin = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    dones = 0;
    for (int k = 1; k <= 9; k++) begin
      op_a = 8'($urandom); op_b = 8'($urandom);
      @(posedge clk); #1;
      if (done8) dones++;
    end
    check("busy_ign_dones", dones, 1);
    check("busy_ign_sum", sum8, 8'h33);
    check("busy_ign_idle", busy8, 0);
    op_a = 8'h40; op_b = 8'h05; cin = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("reaccept_busy", busy8, 1);
    edges = 0;
    while (!done8 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check("reaccept_latency", edges, 8);
    check("reaccept_sum", sum8, 8'h46);
    check("reaccept_cout", cout8, 0);
    @(posedge clk); #1;
    prev_sum[0] = 8'h46;

    // Asynchronous reset in the middle of an operation.
    op_a = 8'hAA; op_b = 8'h55; cin = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy8, 0);
    check("midrst_done", done8, 0);
    check("midrst_sum", sum8, 0);
    check("midrst_cout", cout8, 0);
    for (int i = 0; i < 3; i++) prev_sum[i] = 8'h00;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8, 8'h01, 8'h02, 1'b0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    run_op(8, 8'h10, 8'h01, 1'b0, 1'b1);
    run_op(8, 8'h01, 8'h02, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) run_op(8, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
`endif

    for (int i = 0; i < 40; i++) run_op(8, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);

    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++) run_op(2, 8'(a), 8'(b), 1'(c), 1'b0);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) run_op(4, 8'(a), 8'(b), 1'(c), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
